mem_handshake: RTL and testbench

MEM_HANDSHAKE -- requirements
Module: mem_handshake

---
 rtl/mem_handshake_pkg.sv | 22 ++
 rtl/mem_array.sv | 27 ++
 rtl/mem_handshake.sv | 128 ++++++++++++
 tb/tb_mem_handshake.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_handshake_pkg.sv
// Shared word size, FSM state encoding and range helper for the memory handshake block.
// Pure definitions: no latency, no backpressure.
package mem_handshake_pkg;

   localparam int WORD_SIZE = 16;

   typedef logic [WORD_SIZE-1:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_DONE = 2'd2,
      ST_WR_DONE = 2'd3
   } state_e;

   localparam word_t OOR_READ_VAL = 16'hFFFF;

   function automatic logic addr_in_range(input word_t a, input int depth);
      return int'(a) < depth;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port, contents survive reset.
// Write lands on the clock edge; read is same-cycle; never stalls.
module mem_array
   import mem_handshake_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  word_t         wdata_i,
   input  logic [AW-1:0] raddr_i,
   output word_t         rdata_o
);

   word_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_handshake.sv
// Level-handshake CPU memory port: write acks 1 cycle after request, read data READ_LATENCY+1 cycles after capture,
// outputs held until the request drops. MEM_RANGE_CHECK_EN: out-of-range reads give FFFF, writes dropped; else address wraps.
module mem_handshake
   import mem_handshake_pkg::*;
#(
   parameter int MEM_DEPTH    = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 readM,
   input  logic                 writeM,
   input  logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   output logic                 inputReady,
   output logic                 ackOutput
);

   localparam int AW = $clog2(MEM_DEPTH);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          rdok_q, rdok_d;
   logic [3:0]    cnt_q, cnt_d;
   word_t         rdat_q, rdat_d;
   logic          rdy_q, rdy_d;
   logic          ack_q, ack_d;

   logic          mem_we;
   logic          in_range;
   word_t         mem_rdata;
   word_t         rd_word;

`ifdef MEM_RANGE_CHECK_EN
   assign in_range = addr_in_range(address, MEM_DEPTH);
`else
   logic unused_addr_hi;
   assign in_range       = 1'b1;
   assign unused_addr_hi = ^address[WORD_SIZE-1:AW];
`endif

   // Range verdict is captured with the address so later bus changes cannot alter an in-flight read.
   assign rd_word = rdok_q ? mem_rdata : OOR_READ_VAL;

   mem_array #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (address[AW-1:0]),
      .wdata_i (data),
      .raddr_i (addr_q),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rdok_d  = rdok_q;
      cnt_d   = cnt_q;
      rdat_d  = rdat_q;
      rdy_d   = rdy_q;
      ack_d   = ack_q;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (writeM) begin
               mem_we  = in_range;
               ack_d   = 1'b1;
               state_d = ST_WR_DONE;
            end else if (readM) begin
               addr_d  = address[AW-1:0];
               rdok_d  = in_range;
               cnt_d   = 4'(READ_LATENCY);
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (!readM) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               rdat_d  = rd_word;
               rdy_d   = 1'b1;
               state_d = ST_RD_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RD_DONE: begin
            if (!readM) begin
               rdy_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_WR_DONE: begin
            if (!writeM) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rdok_q  <= 1'b0;
         cnt_q   <= '0;
         rdat_q  <= '0;
         rdy_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rdok_q  <= rdok_d;
         cnt_q   <= cnt_d;
         rdat_q  <= rdat_d;
         rdy_q   <= rdy_d;
         ack_q   <= ack_d;
      end
   end

   assign inputReady = rdy_q;
   assign ackOutput  = ack_q;
   assign data       = rdy_q ? rdat_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_handshake.sv
// Scoreboard bench for mem_handshake: expected read words queued at request, compared when inputReady rises.
module tb_mem_handshake;

   localparam int DEPTH = 256;
   localparam int RL    = 3;

   logic        clk;
   logic        reset_n;
   logic        readM;
   logic        writeM;
   logic [15:0] address;
   wire  [15:0] data;
   logic        inputReady;
   logic        ackOutput;

   logic        drv_en;
   logic [15:0] wdat;
   assign data = drv_en ? wdat : 16'bz;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] model [DEPTH];
   logic [15:0] exp_q [$];

   mem_handshake #(.MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .readM      (readM),
      .writeM     (writeM),
      .address    (address),
      .data       (data),
      .inputReady (inputReady),
      .ackOutput  (ackOutput)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic model_oor(input logic [15:0] a);
`ifdef MEM_RANGE_CHECK_EN
      return a >= 16'(DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_wr(input logic [15:0] a, input logic [15:0] v);
      logic [7:0] idx;
      idx = a[7:0];
      if (!model_oor(a)) model[idx] = v;
   endtask

   function automatic logic [15:0] model_rd(input logic [15:0] a);
      logic [7:0] idx;
      idx = a[7:0];
      return model_oor(a) ? 16'hFFFF : model[idx];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left 1ns after a rising edge.
   task automatic do_write(input logic [15:0] a, input logic [15:0] v);
      int n;
      model_wr(a, v);
      writeM = 1'b1; address = a; wdat = v; drv_en = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!ackOutput && n < 20);
      check_eq("wr_lat", n, 1);
      address = ~a; wdat = ~v;
      repeat (2) begin
         tick();
         check_eq("wr_hold", {31'd0, ackOutput}, 1);
         check_eq("wr_excl", {31'd0, inputReady}, 0);
      end
      writeM = 1'b0; drv_en = 1'b0;
      tick();
      check_eq("wr_done", {31'd0, ackOutput}, 0);
   endtask

   // n counts edges including the capture edge.
   task automatic do_read(input logic [15:0] a);
      int n;
      logic [15:0] e;
      exp_q.push_back(model_rd(a));
      readM = 1'b1; address = a;
      n = 0;
      do begin
         tick(); n++;
         if (n == 1) address = a ^ 16'h00F0;
      end while (!inputReady && n < 40);
      check_eq("rd_lat", n, RL + 2);
      e = exp_q.pop_front();
      check_eq("rd_dat", {16'd0, data}, {16'd0, e});
      check_eq("rd_excl", {31'd0, ackOutput}, 0);
      readM = 1'b0;
      tick(); n++;
      check_eq("rd_idle", {31'd0, inputReady}, 0);
      check_eq("rd_turn", n, RL + 3);
   endtask

   initial begin
      int n;
      int seen;
      logic [15:0] e;
      logic [15:0] ra;
      logic [15:0] rv;

      reset_n = 1'b0; readM = 1'b0; writeM = 1'b0; address = '0;
      drv_en = 1'b0; wdat = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rdy", {31'd0, inputReady}, 0);
      check_eq("rst_ack", {31'd0, ackOutput}, 0);
      reset_n = 1'b1;
      tick();

      // Write then read back.
      do_write(16'd5, 16'h1234);
      do_read(16'd5);

      // Simultaneous read and write: write wins, read follows.
      model_wr(16'd7, 16'hBEEF);
      exp_q.push_back(model_rd(16'd7));
      readM = 1'b1; writeM = 1'b1; address = 16'd7; wdat = 16'hBEEF; drv_en = 1'b1;
      tick();
      check_eq("rw_ack", {31'd0, ackOutput}, 1);
      check_eq("rw_nordy", {31'd0, inputReady}, 0);
      writeM = 1'b0; drv_en = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!inputReady && n < 40);
      check_eq("rw_lat", n, RL + 3);
      e = exp_q.pop_front();
      check_eq("rw_dat", {16'd0, data}, {16'd0, e});
      readM = 1'b0;
      tick();
      check_eq("rw_idle", {31'd0, inputReady}, 0);

      // Read aborted during the wait period.
      readM = 1'b1; address = 16'd5;
      tick(); tick();
      readM = 1'b0;
      seen = 0;
      repeat (8) begin
         tick();
         if (inputReady) seen++;
      end
      check_eq("abort_rdy", seen, 0);
      check_eq("abort_state", {30'd0, u_dut.state_q}, 0);

      // Reset while read data is presented.
      do_write(16'd20, 16'hC3C3);
      readM = 1'b1; address = 16'd20;
      n = 0;
      do begin tick(); n++; end while (!inputReady && n < 40);
      check_eq("rst_pre_rdy", {31'd0, inputReady}, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_async_rdy", {31'd0, inputReady}, 0);
      check_eq("rst_async_ack", {31'd0, ackOutput}, 0);
      readM = 1'b0;
      #2 reset_n = 1'b1;
      tick();
      do_read(16'd20);
      do_read(16'd5);

      // Out-of-range / aliasing address.
      do_write(16'd3, 16'h5555);
      do_write(16'd259, 16'hAAAA);
      do_read(16'd259);
      do_read(16'd3);

      // Back-to-back reads.
      do_write(16'd100, 16'h0F0F);
      do_write(16'd255, 16'h8001);
      do_read(16'd100);
      do_read(16'd255);
      do_read(16'd7);
      do_read(16'd0);

      // Random in-range traffic.
      for (int k = 0; k < 6; k++) begin
         ra = 16'($urandom_range(0, DEPTH - 1));
         rv = 16'($urandom);
         do_write(ra, rv);
         do_read(ra);
      end

      check_eq("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   always @(negedge clk) begin
      if (reset_n && inputReady && ackOutput) begin
         check_eq("excl", {30'd0, inputReady, ackOutput}, 32'd0);
      end
   end

endmodule
